// File: rtl/man_encoding_master.sv
// Manchester frame transmitter: serialises {ST,SB,A4..A0,I4..I0,PB,EB} MSB first,
// then holds the line idle-high for a fixed pause before accepting the next start.
module man_encoding_master #(
  parameter int unsigned HALF_BIT  = 36,
  parameter int unsigned FRAME_LEN = 14,
  parameter int unsigned PAUSE_LEN = 216
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       sb,
  input  logic [4:0] addr,
  input  logic [4:0] info,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       manchester
);

  localparam int unsigned HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned PW = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [HW-1:0]        half_cnt;
  logic [BW-1:0]        bit_idx;
  logic [PW-1:0]        pause_cnt;
  logic                 phase;

  logic        parity_c;
  logic [13:0] frame_c;
  logic        half_last_c;
  logic        bit_last_c;
  logic        pause_last_c;
  logic        done_next_c;

  // Frame assembly with even parity over SB, address and info
  always_comb begin
    parity_c     = ^{sb, addr, info};
    frame_c      = {1'b0, sb, addr, info, parity_c, 1'b1};
    half_last_c  = (half_cnt == HW'(HALF_BIT - 1));
    bit_last_c   = (bit_idx == '0);
    pause_last_c = (pause_cnt == PW'(PAUSE_LEN - 1));
    // done is registered, so it is armed one cycle before the final EB cycle
    done_next_c  = phase && bit_last_c && (half_cnt == HW'(HALF_BIT - 2));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      half_cnt   <= '0;
      bit_idx    <= '0;
      pause_cnt  <= '0;
      phase      <= 1'b0;
      manchester <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SEND;
            shreg      <= FRAME_LEN'(frame_c);
            manchester <= ~frame_c[13];
            half_cnt   <= '0;
            bit_idx    <= BW'(FRAME_LEN - 1);
            phase      <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
          end
        end

        SEND: begin
          done <= done_next_c;
          if (!half_last_c) begin
            half_cnt <= half_cnt + HW'(1);
          end else begin
            half_cnt <= '0;
            if (!phase) begin
              phase      <= 1'b1;
              manchester <= shreg[FRAME_LEN-1];
            end else if (!bit_last_c) begin
              // Next bit starts with the inverse of its value
              phase      <= 1'b0;
              bit_idx    <= bit_idx - BW'(1);
              shreg      <= shreg << 1;
              manchester <= ~shreg[FRAME_LEN-2];
            end else begin
              state      <= PAUSE;
              phase      <= 1'b0;
              shreg      <= '0;
              pause_cnt  <= '0;
              manchester <= 1'b1;
            end
          end
        end

        PAUSE: begin
          manchester <= 1'b1;
          if (pause_last_c) begin
            state     <= IDLE;
            pause_cnt <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
          end else begin
            pause_cnt <= pause_cnt + PW'(1);
          end
        end

        default: begin
          state      <= IDLE;
          manchester <= 1'b1;
          ready      <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_man_encoding_master.sv
// Directed/table-driven bench for man_encoding_master with a mid-bit sampling loopback decoder.
module tb_man_encoding_master;

  localparam int HB     = 36;
  localparam int FL     = 14;
  localparam int PL     = 216;
  localparam int FR_CYC = FL * 2 * HB;

  logic       clk_in;
  logic       rst;
  logic       start;
  logic       sb;
  logic [4:0] addr;
  logic [4:0] info;
  logic       ready;
  logic       busy;
  logic       done;
  logic       manchester;

  int n_cmp;
  int n_bad;

  man_encoding_master #(
    .HALF_BIT (HB),
    .FRAME_LEN(FL),
    .PAUSE_LEN(PL)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (start),
    .sb        (sb),
    .addr      (addr),
    .info      (info),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .manchester(manchester)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sb;
    logic [4:0] addr;
    logic [4:0] info;
    logic [13:0] frame;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] frame_of(input logic s, input logic [4:0] a, input logic [4:0] i);
    logic p;
    p = s ^ (^a) ^ (^i);
    return {1'b0, s, a, i, p, 1'b1};
  endfunction

  // Called at a negedge with the DUT idle; leaves the bench at SEND cycle 0
  task automatic kick(input string nm, input logic s, input logic [4:0] a, input logic [4:0] i,
                      input bit keep);
    sb = s; addr = a; info = i; start = 1'b1;
    chk({nm, "_ready_before"}, 32'(ready), 32'd1);
    @(negedge clk_in);
    if (!keep) start = 1'b0;
  endtask

  // Checks a full SEND window and the following pause; ends at the negedge of the IDLE cycle
  task automatic run_frame(input string nm, input logic [13:0] exp, input int repulse_at,
                           input bit keep);
    int wave_bad;
    int first_bad;
    int busy_bad;
    int done_cnt;
    int done_at;
    int pause_bad;
    logic [13:0] dec;
    wave_bad = 0; first_bad = -1; busy_bad = 0; done_cnt = 0; done_at = -1;
    pause_bad = 0; dec = '0;
    for (int t = 0; t < FR_CYC; t++) begin
      int   k;
      logic b;
      logic lvl;
      k   = t / (2 * HB);
      b   = exp[13 - k];
      lvl = (((t / HB) % 2) == 1) ? b : ~b;
      if (manchester !== lvl) begin
        wave_bad++;
        if (first_bad < 0) first_bad = t;
      end
      if (busy !== 1'b1 || ready !== 1'b0) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = t;
      end
      if ((t % (2 * HB)) == (HB + HB / 2)) dec = {dec[12:0], manchester};
      if (t == 0) begin
        sb = 1'($urandom); addr = 5'($urandom); info = 5'($urandom);
      end
      if (t == repulse_at) start = 1'b1;
      if (t == repulse_at + 1 && !keep) start = 1'b0;
      @(negedge clk_in);
    end
    chk({nm, "_wave_bad_cycles"}, 32'(wave_bad), 32'd0);
    if (first_bad >= 0) $display("  first wrong level at send cycle %0d", first_bad);
    chk({nm, "_loopback"}, 32'(dec), 32'(exp));
    chk({nm, "_busy_in_send"}, 32'(busy_bad), 32'd0);
    chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({nm, "_done_cycle"}, 32'(done_at), 32'(FR_CYC - 1));
    for (int p = 0; p < PL; p++) begin
      if (manchester !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) pause_bad++;
      @(negedge clk_in);
    end
    chk({nm, "_pause_bad_cycles"}, 32'(pause_bad), 32'd0);
    chk({nm, "_ready_after"}, 32'(ready), 32'd1);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; sb = 1'b0; addr = '0; info = '0;

    vecs[0] = '{1'b0, 5'h0A, 5'h03, 14'b00010100001101};
    vecs[1] = '{1'b0, 5'h01, 5'h00, 14'b00000010000011};
    vecs[2] = '{1'b1, 5'h1F, 5'h1F, 14'b01111111111111};
    vecs[3] = '{1'b1, 5'h00, 5'h00, 14'b01000000000011};
    vecs[4] = '{1'b0, 5'h15, 5'h0A, 14'b00101010101011};

    repeat (3) @(negedge clk_in);
    chk("reset_manchester", 32'(manchester), 32'd1);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Table of hand-computed frames; inputs are scrambled right after acceptance
    for (int v = 0; v < 5; v++) begin
      kick($sformatf("vec%0d", v), vecs[v].sb, vecs[v].addr, vecs[v].info, 1'b0);
      run_frame($sformatf("vec%0d", v), vecs[v].frame, -1, 1'b0);
    end

    // Start re-pulsed mid-frame is neither honoured nor queued
    kick("repulse", 1'b1, 5'h12, 5'h05, 1'b0);
    run_frame("repulse", frame_of(1'b1, 5'h12, 5'h05), 500, 1'b0);
    repeat (3) @(negedge clk_in);
    chk("repulse_not_queued", 32'(busy), 32'd0);

    // Start held high: three back-to-back frames
    kick("held0", 1'b0, 5'h0A, 5'h03, 1'b1);
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("held%0d", f), vecs[0].frame, -1, 1'b1);
      if (f < 2) begin
        sb = 1'b0; addr = 5'h0A; info = 5'h03;
        @(negedge clk_in);
      end
    end
    start = 1'b0;
    @(negedge clk_in);
    chk("held_stop_idle", 32'(busy), 32'd0);

    // Asynchronous abort mid-frame, then an immediate clean frame
    kick("abort", 1'b1, 5'h1F, 5'h00, 1'b0);
    repeat (300) @(negedge clk_in);
    rst = 1'b1;
    #1;
    chk("abort_manchester", 32'(manchester), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    begin
      int dseen;
      dseen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk_in);
        if (done !== 1'b0 || manchester !== 1'b1) dseen++;
      end
      chk("abort_quiet", 32'(dseen), 32'd0);
    end
    rst = 1'b0;
    kick("post_abort", 1'b0, 5'h01, 5'h00, 1'b0);
    run_frame("post_abort", vecs[1].frame, -1, 1'b0);

    // Loopback over random field sets
    for (int r = 0; r < 16; r++) begin
      logic       s;
      logic [4:0] a;
      logic [4:0] i;
      s = 1'($urandom); a = 5'($urandom); i = 5'($urandom);
      kick($sformatf("rnd%0d", r), s, a, i, 1'b0);
      run_frame($sformatf("rnd%0d", r), frame_of(s, a, i), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
